fm_tune_ctrl: RTL and testbench

Retune sequencer for the FM receive chain. Accepts a centre-frequency request in 1 kHz steps and converts it into the 32-bit DDS frequency word with a serial shift-add multiplier, so no DSP block is used. After loading the new word it holds a mute flag while the downstream mixer, FIR and CIC stages flush stale samples, then reports completion. It sits between the host/tuning logic and the NCO `Fword` input of the demodulator, all on the `clk_data` domain.

---
 rtl/fm_tune_ctrl_if.sv | 33 +++
 rtl/fm_tune_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fm_tune_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_tune_ctrl_if.sv
// Host-side tuning handshake and NCO word output for the FM retune sequencer.
interface fm_tune_ctrl_if;
  logic        tune_req;
  logic [14:0] cen_freq;
  logic [31:0] fword;
  logic        fword_valid;
  logic        mute;
  logic        busy;
  logic        tune_done;
  logic        tune_err;

  modport master (
    output tune_req,
    output cen_freq,
    input  fword,
    input  fword_valid,
    input  mute,
    input  busy,
    input  tune_done,
    input  tune_err
  );

  modport slave (
    input  tune_req,
    input  cen_freq,
    output fword,
    output fword_valid,
    output mute,
    output busy,
    output tune_done,
    output tune_err
  );
endinterface

// File: rtl/fm_tune_ctrl.sv
// Retune sequencer: kHz request -> 32-bit DDS word via serial shift-add, then mute while the
// downstream filters flush. Single-entry newest-wins pending request while busy.
module fm_tune_ctrl #(
  parameter int unsigned K_PER_KHZ   = 20649,
  parameter int unsigned MAX_KHZ     = 28000,
  parameter int unsigned SETTLE_CYC  = 2048,
  parameter int unsigned RESET_FWORD = 233332358
) (
  input  logic          clk_data,
  input  logic          rst_n,
  fm_tune_ctrl_if.slave bus
);

  localparam logic [31:0] KWord      = 32'(K_PER_KHZ);
  localparam logic [14:0] MaxKhz     = 15'(MAX_KHZ);
  localparam logic [15:0] SettleLast = 16'(SETTLE_CYC - 1);
  localparam logic [31:0] ResetFword = 32'(RESET_FWORD);

  typedef enum logic [1:0] {StIdle, StMult, StLoad, StSettle} state_e;

  state_e      state_q, state_d;

  logic [14:0] mcand_q, mcand_d;
  logic [31:0] addend_q, addend_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [14:0] pend_freq_q, pend_freq_d;
  logic        pend_valid_q, pend_valid_d;

  logic [31:0] fword_q, fword_d;
  logic        fword_valid_q, fword_valid_d;
  logic        mute_q, mute_d;
  logic        busy_q, busy_d;
  logic        tune_done_q, tune_done_d;
  logic        tune_err_q, tune_err_d;

  logic        req_ok;
  logic        req_bad;
  logic        settle_last;
  logic        restart;
  logic        start;
  logic [14:0] start_freq;

  assign req_ok      = bus.tune_req && (bus.cen_freq <= MaxKhz);
  assign req_bad     = bus.tune_req && (bus.cen_freq > MaxKhz);
  assign settle_last = (state_q == StSettle) && (settle_cnt_q == SettleLast);

  // A request landing on the final settle edge is the newest one, so it beats the stored entry.
  assign restart    = settle_last && (req_ok || pend_valid_q);
  assign start      = ((state_q == StIdle) && req_ok) || restart;
  assign start_freq = req_ok ? bus.cen_freq : pend_freq_q;

  // State register
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_ok) state_d = StMult;
      StMult:   if (bit_cnt_q == 4'd14) state_d = StLoad;
      StLoad:   state_d = StSettle;
      StSettle: if (settle_last) state_d = restart ? StMult : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    mcand_d       = mcand_q;
    addend_d      = addend_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    pend_freq_d   = pend_freq_q;
    pend_valid_d  = pend_valid_q;
    fword_d       = fword_q;
    fword_valid_d = 1'b0;
    tune_done_d   = 1'b0;
    tune_err_d    = req_bad;
    mute_d        = mute_q;
    busy_d        = busy_q;

    if (start) begin
      mcand_d   = start_freq;
      addend_d  = KWord;
      acc_d     = '0;
      bit_cnt_d = '0;
      mute_d    = 1'b1;
      busy_d    = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
      end
      StMult: begin
        // Addend tracks K << bit_cnt, so no barrel shifter is needed.
        if (mcand_q[0]) acc_d = acc_q + addend_q;
        mcand_d   = mcand_q >> 1;
        addend_d  = addend_q << 1;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      StLoad: begin
        fword_d       = acc_q;
        fword_valid_d = 1'b1;
        settle_cnt_d  = '0;
      end
      StSettle: begin
        settle_cnt_d = settle_cnt_q + 16'd1;
        if (settle_last) begin
          tune_done_d  = 1'b1;
          pend_valid_d = 1'b0;
          if (!restart) begin
            mute_d = 1'b0;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
      end
    endcase

    if (req_ok && (state_q != StIdle) && !settle_last) begin
      pend_freq_d  = bus.cen_freq;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q       <= '0;
      addend_q      <= '0;
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      pend_freq_q   <= '0;
      pend_valid_q  <= 1'b0;
      fword_q       <= ResetFword;
      fword_valid_q <= 1'b0;
      mute_q        <= 1'b0;
      busy_q        <= 1'b0;
      tune_done_q   <= 1'b0;
      tune_err_q    <= 1'b0;
    end else begin
      mcand_q       <= mcand_d;
      addend_q      <= addend_d;
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      pend_freq_q   <= pend_freq_d;
      pend_valid_q  <= pend_valid_d;
      fword_q       <= fword_d;
      fword_valid_q <= fword_valid_d;
      mute_q        <= mute_d;
      busy_q        <= busy_d;
      tune_done_q   <= tune_done_d;
      tune_err_q    <= tune_err_d;
    end
  end

  assign bus.fword       = fword_q;
  assign bus.fword_valid = fword_valid_q;
  assign bus.mute        = mute_q;
  assign bus.busy        = busy_q;
  assign bus.tune_done   = tune_done_q;
  assign bus.tune_err    = tune_err_q;

`ifndef SYNTHESIS
  a_busy_state : assert property (@(posedge clk_data) disable iff (!rst_n)
    busy_q == (state_q != StIdle));
  a_mute_busy : assert property (@(posedge clk_data) disable iff (!rst_n)
    mute_q == busy_q);
  a_valid_settle : assert property (@(posedge clk_data) disable iff (!rst_n)
    fword_valid_q |-> (state_q == StSettle));
`endif

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Directed bench for fm_tune_ctrl: word values, pulse timing, pending/err handling, async reset.
module tb_fm_tune_ctrl;

  localparam logic [31:0] FwReset = 32'd233332358;
  localparam logic [31:0] Fw11300 = 32'd233333700;
  localparam logic [31:0] Fw28000 = 32'd578172000;
  localparam logic [31:0] Fw10000 = 32'd206490000;
  localparam logic [31:0] Fw1000  = 32'd20649000;
  localparam logic [31:0] Fw200   = 32'd4129800;
  localparam int          Lim     = 2200;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fm_tune_ctrl_if bus ();

  fm_tune_ctrl #(
    .K_PER_KHZ  (20649),
    .MAX_KHZ    (28000),
    .SETTLE_CYC (2048),
    .RESET_FWORD(233332358)
  ) dut (
    .clk_data(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request at the current negedge and measures the resulting tune.
  task automatic do_tune(input logic [14:0] f, output logic b0, output logic [31:0] fw_pre,
                         output int fv_at, output int fv_cnt, output logic [31:0] fw_v,
                         output int td_at, output int mute_low, output logic [1:0] end_mb);
    bus.tune_req = 1'b1;
    bus.cen_freq = f;
    b0 = 1'b0; fw_pre = '0; fv_at = -1; fv_cnt = 0; fw_v = '0; td_at = -1; mute_low = 0;
    end_mb = 2'b11;
    for (int k = 0; k < Lim; k++) begin
      @(negedge clk);
      bus.tune_req = 1'b0;
      if (k == 0) b0 = bus.busy;
      if (k == 15) fw_pre = bus.fword;
      if (bus.fword_valid) begin
        fv_cnt++;
        if (fv_at < 0) begin fv_at = k; fw_v = bus.fword; end
      end
      if (bus.tune_done) begin td_at = k; end_mb = {bus.mute, bus.busy}; break; end
      if (!bus.mute) mute_low++;
    end
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    rst_n = 1'b0;
    bus.tune_req = 1'b0;
    bus.cen_freq = '0;
    repeat (3) @(negedge clk);
    obs = {bus.fword, bus.mute, bus.busy, bus.fword_valid, bus.tune_done, bus.tune_err};
    total++;
    if (obs !== {FwReset, 5'b0}) begin
      bad++; $display("FAIL reset_held got=%h want=%h", obs, {FwReset, 5'b0});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      obs = {bus.fword, bus.mute, bus.busy, bus.fword_valid, bus.tune_done, bus.tune_err};
      total++;
      if (obs !== {FwReset, 5'b0}) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", k, obs, {FwReset, 5'b0});
      end
    end
  endtask

  task automatic test_basic();
    logic b0; logic [31:0] fw_pre, fw_v; int fv_at, fv_cnt, td_at, mute_low; logic [1:0] end_mb;
    do_tune(15'd11300, b0, fw_pre, fv_at, fv_cnt, fw_v, td_at, mute_low, end_mb);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL basic_busy_e0 got=%b want=1", b0); end
    total++;
    if (fw_pre !== FwReset) begin
      bad++; $display("FAIL basic_fword_pre got=%0d want=%0d", fw_pre, FwReset);
    end
    total++; if (fv_at !== 16) begin bad++; $display("FAIL basic_fv_at got=%0d want=16", fv_at); end
    total++; if (fv_cnt !== 1) begin bad++; $display("FAIL basic_fv_cnt got=%0d want=1", fv_cnt); end
    total++;
    if (fw_v !== Fw11300) begin bad++; $display("FAIL basic_fword got=%0d want=%0d", fw_v, Fw11300); end
    total++; if (td_at !== 2064) begin bad++; $display("FAIL basic_td_at got=%0d want=2064", td_at); end
    total++;
    if (mute_low !== 0) begin bad++; $display("FAIL basic_mute_gap got=%0d want=0", mute_low); end
    total++;
    if (end_mb !== 2'b00) begin bad++; $display("FAIL basic_end_mute_busy got=%b want=00", end_mb); end
  endtask

  task automatic test_bounds_back_to_back();
    logic b0; logic [31:0] fw_pre, fw_v; int fv_at, fv_cnt, td_at, mute_low; logic [1:0] end_mb;
    do_tune(15'd0, b0, fw_pre, fv_at, fv_cnt, fw_v, td_at, mute_low, end_mb);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL zero_b2b_accept got=%b want=1", b0); end
    total++; if (fw_v !== 32'd0) begin bad++; $display("FAIL zero_fword got=%0d want=0", fw_v); end
    total++; if (fv_cnt !== 1) begin bad++; $display("FAIL zero_fv_cnt got=%0d want=1", fv_cnt); end
    total++; if (td_at !== 2064) begin bad++; $display("FAIL zero_td_at got=%0d want=2064", td_at); end
    do_tune(15'd28000, b0, fw_pre, fv_at, fv_cnt, fw_v, td_at, mute_low, end_mb);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL max_b2b_accept got=%b want=1", b0); end
    total++; if (fw_pre !== 32'd0) begin bad++; $display("FAIL max_fword_pre got=%0d want=0", fw_pre); end
    total++;
    if (fw_v !== Fw28000) begin bad++; $display("FAIL max_fword got=%0d want=%0d", fw_v, Fw28000); end
    total++; if (fv_cnt !== 1) begin bad++; $display("FAIL max_fv_cnt got=%0d want=1", fv_cnt); end
    total++; if (fv_at !== 16) begin bad++; $display("FAIL max_fv_at got=%0d want=16", fv_at); end
  endtask

  task automatic test_err();
    int td_at;
    bus.tune_req = 1'b1;
    bus.cen_freq = 15'd28001;
    @(negedge clk);
    bus.tune_req = 1'b0;
    total++;
    if ({bus.tune_err, bus.busy} !== 2'b10) begin
      bad++; $display("FAIL err_idle_pulse got=%b want=10", {bus.tune_err, bus.busy});
    end
    total++;
    if (bus.fword !== Fw28000) begin
      bad++; $display("FAIL err_idle_fword got=%0d want=%0d", bus.fword, Fw28000);
    end
    @(negedge clk);
    total++;
    if ({bus.tune_err, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL err_idle_after got=%b want=00", {bus.tune_err, bus.busy});
    end
    bus.tune_req = 1'b1;
    bus.cen_freq = 15'd1000;
    td_at = -1;
    for (int k = 0; k < Lim; k++) begin
      @(negedge clk);
      bus.tune_req = 1'b0;
      if (k == 2) begin
        total++;
        if ({bus.tune_err, bus.busy} !== 2'b11) begin
          bad++; $display("FAIL err_busy_pulse got=%b want=11", {bus.tune_err, bus.busy});
        end
      end
      if (k == 3) begin
        total++;
        if (bus.tune_err !== 1'b0) begin bad++; $display("FAIL err_busy_len got=%b want=0", bus.tune_err); end
      end
      if (bus.tune_done) begin td_at = k; break; end
      if (k == 1) begin bus.tune_req = 1'b1; bus.cen_freq = 15'd28001; end
    end
    total++; if (td_at !== 2064) begin bad++; $display("FAIL err_busy_td_at got=%0d want=2064", td_at); end
    repeat (20) @(negedge clk);
    total++;
    if ({bus.busy, bus.fword} !== {1'b0, Fw1000}) begin
      bad++; $display("FAIL err_no_pending got=%b/%0d want=0/%0d", bus.busy, bus.fword, Fw1000);
    end
  endtask

  task automatic test_pending();
    int fv_cnt, td_cnt, mute_low, fv2_at, td2_at;
    logic [31:0] fw2;
    fv_cnt = 0; td_cnt = 0; mute_low = 0; fv2_at = -1; td2_at = -1; fw2 = '0;
    bus.tune_req = 1'b1;
    bus.cen_freq = 15'd11300;
    for (int k = 0; k < 4400; k++) begin
      @(negedge clk);
      bus.tune_req = 1'b0;
      if (bus.fword_valid) begin
        fv_cnt++;
        if (fv_cnt == 2) begin fv2_at = k; fw2 = bus.fword; end
      end
      if (bus.tune_done) begin
        td_cnt++;
        if (td_cnt == 2) begin td2_at = k; break; end
      end
      if (!bus.mute) mute_low++;
      if (k == 99) begin bus.tune_req = 1'b1; bus.cen_freq = 15'd9000; end
      if (k == 199) begin bus.tune_req = 1'b1; bus.cen_freq = 15'd10000; end
    end
    total++; if (fv_cnt !== 2) begin bad++; $display("FAIL pend_fv_cnt got=%0d want=2", fv_cnt); end
    total++; if (fv2_at !== 2080) begin bad++; $display("FAIL pend_fv2_at got=%0d want=2080", fv2_at); end
    total++;
    if (fw2 !== Fw10000) begin bad++; $display("FAIL pend_newest got=%0d want=%0d", fw2, Fw10000); end
    total++; if (td2_at !== 4128) begin bad++; $display("FAIL pend_td2_at got=%0d want=4128", td2_at); end
    total++; if (mute_low !== 0) begin bad++; $display("FAIL pend_mute_gap got=%0d want=0", mute_low); end
    repeat (20) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL pend_single got=%b want=0", bus.busy); end
  endtask

  task automatic test_done_edge();
    bus.tune_req = 1'b1;
    bus.cen_freq = 15'd100;
    for (int k = 0; k < 4400; k++) begin
      @(negedge clk);
      bus.tune_req = 1'b0;
      if (k == 2064) begin
        total++;
        if ({bus.tune_done, bus.busy, bus.mute} !== 3'b111) begin
          bad++; $display("FAIL edge_restart got=%b want=111", {bus.tune_done, bus.busy, bus.mute});
        end
      end
      if (k == 2080) begin
        total++;
        if ({bus.fword_valid, bus.fword} !== {1'b1, Fw200}) begin
          bad++; $display("FAIL edge_fword got=%b/%0d want=1/%0d", bus.fword_valid, bus.fword, Fw200);
        end
      end
      if (k == 4128) begin
        total++;
        if ({bus.tune_done, bus.tune_err, bus.busy} !== 3'b110) begin
          bad++; $display("FAIL edge_err_done got=%b want=110",
                          {bus.tune_done, bus.tune_err, bus.busy});
        end
        break;
      end
      if (k == 2063) begin bus.tune_req = 1'b1; bus.cen_freq = 15'd200; end
      if (k == 4127) begin bus.tune_req = 1'b1; bus.cen_freq = 15'd28001; end
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] obs;
    logic b0; logic [31:0] fw_pre, fw_v; int fv_at, fv_cnt, td_at, mute_low; logic [1:0] end_mb;
    bus.tune_req = 1'b1;
    bus.cen_freq = 15'd11300;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      bus.tune_req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    obs = {bus.fword, bus.mute, bus.busy, bus.fword_valid, bus.tune_done, bus.tune_err};
    total++;
    if (obs !== {FwReset, 5'b0}) begin
      bad++; $display("FAIL rstmid_async got=%h want=%h", obs, {FwReset, 5'b0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", bus.busy); end
    do_tune(15'd11300, b0, fw_pre, fv_at, fv_cnt, fw_v, td_at, mute_low, end_mb);
    total++;
    if (fw_pre !== FwReset) begin
      bad++; $display("FAIL rstmid_fword_pre got=%0d want=%0d", fw_pre, FwReset);
    end
    total++;
    if ({fv_at, fw_v} !== {32'sd16, Fw11300}) begin
      bad++; $display("FAIL rstmid_fword got=%0d@%0d want=%0d@16", fw_v, fv_at, Fw11300);
    end
    total++; if (td_at !== 2064) begin bad++; $display("FAIL rstmid_td_at got=%0d want=2064", td_at); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_bounds_back_to_back();
    test_err();
    test_pending();
    test_done_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
